pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 id_allowin  in  1  ID stage can accept the held instruction this cycle.
REQ-005 br_taken  in  1  branch redirect request from ID; br_target  in  32  its target.
REQ-006 ex_flush  in  1  exception/eret redirect from WB; ex_target  in  32  its target.
REQ-007 inst_req  out  1  instruction-SRAM request valid; inst_addr  out  32  request address.
REQ-008 inst_addr_ok  in  1  request accepted this cycle; inst_data_ok  in  1  read data valid this cycle; inst_rdata  in  32  read data.
REQ-009 if_valid  out  1  if_pc/if_inst/if_adel hold a valid fetch result for ID.
REQ-010 if_pc  out  32; if_inst  out  32; if_adel  out  1  fetch address misaligned.

Function
REQ-011 The block SHALL run an FSM with states REQ, WAIT, VALID, DISCARD, with at most one outstanding SRAM request.
REQ-012 REQ: inst_req=1 and inst_addr=pc when pc[1:0]==0; on inst_addr_ok -> WAIT.
REQ-013 REQ with pc[1:0]!=0: inst_req=0; next cycle -> VALID with if_adel=1, if_inst=0, if_pc=pc.
REQ-014 WAIT: inst_req=0; on inst_data_ok, capture inst_rdata into if_inst, pc into if_pc, if_adel=0 -> VALID (if_valid=1 from the next cycle, fetch latency = 1 cycle after data_ok).
REQ-015 VALID: if_valid=1, outputs held stable while id_allowin=0; when id_allowin=1, pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) -> REQ.
REQ-016 Redirect = ex_flush | br_taken; target = ex_flush ? ex_target : br_target (ex_flush priority when simultaneous).
REQ-017 Redirect in REQ without inst_addr_ok: pc <= target, stay REQ (unaccepted address may change).
REQ-018 Redirect in REQ with inst_addr_ok same cycle: pc <= target -> DISCARD.
REQ-019 Redirect in WAIT without inst_data_ok: pc <= target -> DISCARD; with inst_data_ok same cycle: data dropped, pc <= target -> REQ.
REQ-020 Redirect in VALID: held instruction dropped (if_valid=0 next cycle) regardless of id_allowin, pc <= target -> REQ.
REQ-021 DISCARD: if_valid=0, inst_req=0; on inst_data_ok data is dropped -> REQ; a further redirect overwrites pc.
REQ-022 if_valid SHALL be 0 in every state except VALID.
REQ-023 inst_rdata SHALL be ignored whenever inst_data_ok=0; inst_data_ok in REQ/VALID SHALL be ignored.

Reset
REQ-024 While resetn=0: state=REQ, pc=RESET_PC, inst_req=0, if_valid=0, if_pc=0, if_inst=0, if_adel=0.
REQ-025 First cycle after resetn rises: inst_req=1, inst_addr=RESET_PC.
REQ-026 resetn=0 mid-transaction SHALL abandon the outstanding request; the bench SHALL not return data_ok for it after reset.

Verification
REQ-027 Reset release, addr_ok=1 immediately, data_ok 1 cycle later with 32'h2402_0001, id_allowin=1 -> if_valid=1, if_pc=32'hBFC0_0000, if_inst=32'h2402_0001; next req addr 32'hBFC0_0004.
REQ-028 Backpressure: id_allowin=0 for 5 cycles in VALID -> if_pc/if_inst unchanged, inst_req=0 throughout; release -> next req pc+4.
REQ-029 br_taken=1, br_target=32'h8000_0100 in WAIT; data_ok 3 cycles later with 32'hDEAD_BEEF -> no if_valid for that data; next inst_addr=32'h8000_0100.
REQ-030 ex_flush (ex_target=32'hBFC0_0380) and br_taken (br_target=32'h1000) same cycle in VALID -> if_valid=0 next cycle, next inst_addr=32'hBFC0_0380.
REQ-031 br_target=32'h8000_0102 -> no inst_req; if_valid=1, if_adel=1, if_pc=32'h8000_0102, if_inst=0.
REQ-032 pc=32'hFFFF_FFFC fetched and consumed -> next inst_addr=32'h0000_0000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// IF stage: keeps the PC and fetches one instruction at a time from the instruction SRAM.
// Handles branch/exception redirects and misaligned fetch addresses, and holds the result until ID accepts it.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ex_flush,
    input  logic [31:0] ex_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_VALID   = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        aligned;
    logic        capture;
    logic        capture_adel;

    assign redirect    = ex_flush | br_taken;
    assign redirect_pc = ex_flush ? ex_target : br_target;
    assign aligned     = (pc[1:0] == 2'b00);
    assign inst_addr   = pc;
    assign if_valid    = (state == S_VALID);

    always_comb begin
        next_state   = state;
        next_pc      = pc;
        capture      = 1'b0;
        capture_adel = 1'b0;
        unique case (state)
            S_REQ: begin
                if (redirect) begin
                    // An accepted request cannot be cancelled, so its data must be drained.
                    next_pc    = redirect_pc;
                    next_state = (inst_req && inst_addr_ok) ? S_DISCARD : S_REQ;
                end else if (!aligned) begin
                    capture      = 1'b1;
                    capture_adel = 1'b1;
                    next_state   = S_VALID;
                end else if (inst_req && inst_addr_ok) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    if (redirect) begin
                        next_pc    = redirect_pc;
                        next_state = S_REQ;
                    end else begin
                        capture    = 1'b1;
                        next_state = S_VALID;
                    end
                end else if (redirect) begin
                    next_pc    = redirect_pc;
                    next_state = S_DISCARD;
                end
            end
            S_VALID: begin
                if (redirect) begin
                    next_pc    = redirect_pc;
                    next_state = S_REQ;
                end else if (id_allowin) begin
                    next_pc    = pc + 32'd4;
                    next_state = S_REQ;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    next_pc = redirect_pc;
                end
                if (inst_data_ok) begin
                    next_state = S_REQ;
                end
            end
            default: next_state = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            inst_req <= 1'b0;
            if_pc    <= 32'd0;
            if_inst  <= 32'd0;
            if_adel  <= 1'b0;
        end else begin
            state    <= next_state;
            pc       <= next_pc;
            // Registered so the request tracks the PC it is issued for, including after a redirect.
            inst_req <= (next_state == S_REQ) && (next_pc[1:0] == 2'b00);
            if (capture) begin
                if_pc   <= pc;
                if_inst <= capture_adel ? 32'd0 : inst_rdata;
                if_adel <= capture_adel;
            end
        end
    end

endmodule
